// File: rtl/vec_lsu_if.sv
// Request, memory-beat and writeback signals of the vector load/store unit.
// The slave modport is the LSU side; the master modport is the core/memory side.
interface vec_lsu_if #(
   parameter int unsigned LANES      = 16,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned BEAT_LANES = 4,
   parameter int unsigned REG_AW     = 3
);
   localparam int unsigned NBEATS = LANES / BEAT_LANES;
   localparam int unsigned BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   logic                         req_valid;
   logic                         req_ready;
   logic                         req_is_store;
   logic [ADDR_W-1:0]            req_addr;
   logic [LANES-1:0]             req_mask;
   logic [LANES*DATA_W-1:0]      req_wdata;
   logic [REG_AW-1:0]            req_dest;
   logic                         mem_en;
   logic                         mem_we;
   logic [ADDR_W-1:0]            mem_row;
   logic [BW-1:0]                mem_beat;
   logic [BEAT_LANES*DATA_W-1:0] mem_wdata;
   logic [BEAT_LANES-1:0]        mem_wstrb;
   logic [BEAT_LANES*DATA_W-1:0] mem_rdata;
   logic                         wb_valid;
   logic [REG_AW-1:0]            wb_dest;
   logic [LANES*DATA_W-1:0]      wb_data;
   logic [LANES-1:0]             wb_mask;
   logic                         done;
   logic                         busy;

   modport master (
      output req_valid, req_is_store, req_addr, req_mask, req_wdata, req_dest, mem_rdata,
      input  req_ready, mem_en, mem_we, mem_row, mem_beat, mem_wdata, mem_wstrb,
      input  wb_valid, wb_dest, wb_data, wb_mask, done, busy
   );

   modport slave (
      input  req_valid, req_is_store, req_addr, req_mask, req_wdata, req_dest, mem_rdata,
      output req_ready, mem_en, mem_we, mem_row, mem_beat, mem_wdata, mem_wstrb,
      output wb_valid, wb_dest, wb_data, wb_mask, done, busy
   );
endinterface

// File: rtl/vec_lsu.sv
// Vector load/store unit: moves one masked row per request as BEAT_LANES-wide memory beats,
// skipping all-zero beats, and assembles load data into a single masked writeback.
module vec_lsu #(
   parameter int unsigned LANES      = 16,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned BEAT_LANES = 4,
   parameter int unsigned REG_AW     = 3
) (
   input logic       clk,
   input logic       rst_n,
   vec_lsu_if.slave  bus
);
   localparam int unsigned NBEATS    = LANES / BEAT_LANES;
   localparam int unsigned BW        = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int unsigned BEAT_BITS = BEAT_LANES * DATA_W;

   if (LANES % BEAT_LANES != 0) begin : g_bad_cfg
      $error("vec_lsu: LANES must be a multiple of BEAT_LANES");
   end

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e                  state_q, state_d;
   logic [BW-1:0]           ptr_q, ptr_d;
   logic                    is_store_q;
   logic [ADDR_W-1:0]       addr_q;
   logic [LANES-1:0]        mask_q;
   logic [LANES*DATA_W-1:0] wdata_q;
   logic [REG_AW-1:0]       dest_q;
   logic [LANES*DATA_W-1:0] wb_data_q;
   logic                    cap_valid_q;
   logic [BW-1:0]           cap_beat_q;

   logic [NBEATS-1:0] req_act, cur_act;
   logic [BW-1:0]     first_beat, next_beat;
   logic              has_next;
   logic              accept;

   assign accept = (state_q == StIdle) && bus.req_valid;

   always_comb begin
      req_act    = '0;
      cur_act    = '0;
      first_beat = '0;
      next_beat  = '0;
      has_next   = 1'b0;
      for (int b = 0; b < NBEATS; b++) begin
         req_act[b] = |bus.req_mask[b*BEAT_LANES +: BEAT_LANES];
         cur_act[b] = |mask_q[b*BEAT_LANES +: BEAT_LANES];
      end
      // Descending scans leave the lowest qualifying beat selected.
      for (int b = NBEATS - 1; b >= 0; b--) begin
         if (req_act[b]) first_beat = BW'(b);
         if (cur_act[b] && (b > int'(ptr_q))) begin
            next_beat = BW'(b);
            has_next  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               if (req_act == '0) begin
                  state_d = StDone;
               end else begin
                  state_d = StIssue;
                  ptr_d   = first_beat;
               end
            end
         end
         StIssue: begin
            if (has_next) ptr_d = next_beat;
            else          state_d = is_store_q ? StDone : StDrain;
         end
         StDrain: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.req_ready = (state_q == StIdle);
      bus.busy      = (state_q != StIdle);
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_row   = '0;
      bus.mem_beat  = '0;
      bus.mem_wstrb = '0;
      bus.mem_wdata = '0;
      bus.done      = (state_q == StDone);
      bus.wb_valid  = (state_q == StDone) && !is_store_q;
      if (state_q == StIssue) begin
         bus.mem_en   = 1'b1;
         bus.mem_we   = is_store_q;
         bus.mem_row  = addr_q;
         bus.mem_beat = ptr_q;
         for (int b = 0; b < NBEATS; b++) begin
            if (ptr_q == BW'(b)) begin
               bus.mem_wstrb = mask_q[b*BEAT_LANES +: BEAT_LANES];
               bus.mem_wdata = wdata_q[b*BEAT_BITS +: BEAT_BITS];
            end
         end
      end
   end

   assign bus.wb_dest = dest_q;
   assign bus.wb_mask = mask_q;
   assign bus.wb_data = wb_data_q;

   // Read data arrives one cycle after issue, so capture trails ISSUE by one beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_store_q  <= 1'b0;
         addr_q      <= '0;
         mask_q      <= '0;
         wdata_q     <= '0;
         dest_q      <= '0;
         wb_data_q   <= '0;
         cap_valid_q <= 1'b0;
         cap_beat_q  <= '0;
      end else begin
         cap_valid_q <= (state_q == StIssue) && !is_store_q;
         cap_beat_q  <= ptr_q;
         if (accept) begin
            is_store_q <= bus.req_is_store;
            addr_q     <= bus.req_addr;
            mask_q     <= bus.req_mask;
            wdata_q    <= bus.req_wdata;
            dest_q     <= bus.req_dest;
            wb_data_q  <= '0;
         end else if (cap_valid_q) begin
            for (int b = 0; b < NBEATS; b++) begin
               for (int j = 0; j < BEAT_LANES; j++) begin
                  if ((cap_beat_q == BW'(b)) && mask_q[b*BEAT_LANES + j]) begin
                     wb_data_q[(b*BEAT_LANES + j)*DATA_W +: DATA_W] <=
                        bus.mem_rdata[j*DATA_W +: DATA_W];
                  end
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_vec_lsu.sv
// Directed bench for vec_lsu: beat-level memory model, scoreboard queues of expected beats
// and completions filled when a request is driven and drained by a negedge monitor.
module tb_vec_lsu;
   localparam int unsigned LANES = 16, DATA_W = 32, ADDR_W = 6, BEAT_LANES = 4, REG_AW = 3;

   typedef struct {
      int           cyc;
      logic [1:0]   beat;
      logic         we;
      logic [3:0]   strb;
      logic [127:0] wd;
      logic [5:0]   row;
   } beat_t;

   typedef struct {
      int           cyc;
      logic         wb;
      logic [2:0]   dest;
      logic [15:0]  mask;
      logic [511:0] data;
   } done_t;

   logic clk, rst_n;
   int   checks, errors, cyc;
   beat_t beat_q[$];
   done_t done_q[$];
   bit [127:0] mem    [64][4];
   bit [31:0]  shadow [64][16];

   vec_lsu_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BEAT_LANES(BEAT_LANES),
                .REG_AW(REG_AW)) bus ();

   vec_lsu #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BEAT_LANES(BEAT_LANES),
             .REG_AW(REG_AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Beat-organised data memory, read data registered one cycle after issue.
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) begin
            for (int j = 0; j < 4; j++)
               if (bus.mem_wstrb[j]) mem[bus.mem_row][bus.mem_beat][j*32 +: 32] <= bus.mem_wdata[j*32 +: 32];
         end else begin
            bus.mem_rdata <= mem[bus.mem_row][bus.mem_beat];
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         cyc++;
         if (bus.mem_en) begin
            chk("mem_expected", beat_q.size() > 0, 1'b1);
            if (beat_q.size() > 0) begin
               beat_t e;
               e = beat_q.pop_front();
               chk("mem_cycle", cyc, e.cyc);
               chk("mem_beat", bus.mem_beat, e.beat);
               chk("mem_we", bus.mem_we, e.we);
               chk("mem_wstrb", bus.mem_wstrb, e.strb);
               chk("mem_row", bus.mem_row, e.row);
               if (e.we) chk("mem_wdata", bus.mem_wdata, e.wd);
            end
         end
         if (bus.done) begin
            chk("done_expected", done_q.size() > 0, 1'b1);
            if (done_q.size() > 0) begin
               done_t d;
               d = done_q.pop_front();
               chk("done_cycle", cyc, d.cyc);
               chk("wb_valid", bus.wb_valid, d.wb);
               if (d.wb) begin
                  chk("wb_dest", bus.wb_dest, d.dest);
                  chk("wb_mask", bus.wb_mask, d.mask);
                  chk("wb_data", bus.wb_data, d.data);
               end
            end
         end else begin
            chk("wb_valid_idle", bus.wb_valid, 1'b0);
         end
         if (bus.req_valid && bus.req_ready) cyc = 0;
      end
   end

   function automatic logic [511:0] ramp(input int base, input int step);
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'(base + step*i);
      return v;
   endfunction

   task automatic send(input bit st, input logic [5:0] addr, input logic [15:0] mask,
                       input logic [511:0] wd, input logic [2:0] dest, output int waits);
      int k;
      done_t d;
      logic [511:0] exp_data;
      bus.req_valid    = 1'b1;
      bus.req_is_store = st;
      bus.req_addr     = addr;
      bus.req_mask     = mask;
      bus.req_wdata    = wd;
      bus.req_dest     = dest;
      k = 0;
      for (int b = 0; b < 4; b++) begin
         if (|mask[b*4 +: 4]) begin
            beat_t e;
            e.cyc = k + 1;
            e.beat = 2'(b);
            e.we = st;
            e.strb = mask[b*4 +: 4];
            e.wd = wd[b*128 +: 128];
            e.row = addr;
            beat_q.push_back(e);
            k++;
         end
      end
      exp_data = '0;
      for (int i = 0; i < 16; i++) begin
         if (mask[i]) begin
            if (st) shadow[addr][i] = wd[i*32 +: 32];
            else    exp_data[i*32 +: 32] = shadow[addr][i];
         end
      end
      d.cyc  = (k == 0) ? 1 : (st ? k + 1 : k + 2);
      d.wb   = !st;
      d.dest = dest;
      d.mask = mask;
      d.data = exp_data;
      done_q.push_back(d);
      waits = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.req_ready) break;
         waits++;
      end
      chk("accept_in_time", bus.req_ready, 1'b1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic wait_quiet();
      for (int i = 0; i < 60; i++) begin
         if (beat_q.size() == 0 && done_q.size() == 0) break;
         @(posedge clk);
      end
      chk("complete_in_time", beat_q.size() + done_q.size(), 0);
      #1;
   endtask

   task automatic check_reset_vals(input string pfx);
      chk({pfx, "_req_ready"}, bus.req_ready, 1'b1);
      chk({pfx, "_busy"}, bus.busy, 1'b0);
      chk({pfx, "_mem_en"}, bus.mem_en, 1'b0);
      chk({pfx, "_mem_we"}, bus.mem_we, 1'b0);
      chk({pfx, "_mem_wstrb"}, bus.mem_wstrb, 4'h0);
      chk({pfx, "_mem_row"}, bus.mem_row, 6'h0);
      chk({pfx, "_mem_beat"}, bus.mem_beat, 2'h0);
      chk({pfx, "_mem_wdata"}, bus.mem_wdata, 128'h0);
      chk({pfx, "_done"}, bus.done, 1'b0);
      chk({pfx, "_wb_valid"}, bus.wb_valid, 1'b0);
      chk({pfx, "_wb_dest"}, bus.wb_dest, 3'h0);
      chk({pfx, "_wb_mask"}, bus.wb_mask, 16'h0);
      chk({pfx, "_wb_data"}, bus.wb_data, 512'h0);
   endtask

   initial begin
      int w, w2;
      logic [511:0] row5;
      checks = 0;
      errors = 0;
      cyc = 0;
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_is_store = 1'b0;
      bus.req_addr = '0;
      bus.req_mask = '0;
      bus.req_wdata = '0;
      bus.req_dest = '0;
      repeat (2) @(posedge clk);
      #1 check_reset_vals("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full-mask store, then check the memory row directly.
      row5 = ramp(101, 2);
      send(1'b1, 6'd5, 16'hFFFF, row5, 3'd0, w);
      wait_quiet();
      for (int b = 0; b < 4; b++) chk("mem_row5", mem[5][b], row5[b*128 +: 128]);

      send(1'b0, 6'd5, 16'hFFFF, '0, 3'd4, w);
      wait_quiet();
      send(1'b0, 6'd5, 16'h0F01, '0, 3'd2, w);
      wait_quiet();

      // Zero masks: no memory traffic, immediate completion.
      send(1'b1, 6'd7, 16'h0000, ramp(7, 1), 3'd0, w);
      wait_quiet();
      send(1'b0, 6'd7, 16'h0000, '0, 3'd1, w);
      wait_quiet();

      // Second request held while the first store is busy.
      send(1'b1, 6'd3, 16'hFFFF, ramp(500, 3), 3'd0, w);
      send(1'b0, 6'd3, 16'hF0F0, '0, 3'd5, w2);
      chk("held_req_waits", w2, 5);
      wait_quiet();

      // Abort a full-mask store after beat 1 has been written.
      send(1'b1, 6'd9, 16'hFFFF, ramp(900, 1), 3'd0, w);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_vals("abort");
      chk("abort_beats_left", beat_q.size(), 2);
      chk("abort_done_left", done_q.size(), 1);
      beat_q.delete();
      done_q.delete();
      for (int i = 8; i < 16; i++) shadow[9][i] = '0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("post_abort_ready", bus.req_ready, 1'b1);
      @(posedge clk);
      #1;
      send(1'b0, 6'd5, 16'hFFFF, '0, 3'd4, w);
      wait_quiet();
      send(1'b0, 6'd9, 16'hFFFF, '0, 3'd6, w);
      wait_quiet();

      chk("final_queues_empty", beat_q.size() + done_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vec_lsu.md
# vec_lsu

Parametrised vector load/store unit between the GPU core's decode/execute stage and a beat-organised data memory. It moves one masked vector row (LANES × DATA_W) per request, splitting it into memory beats of BEAT_LANES lanes. Beats whose mask slice is all-zero are skipped. Load results come back as a single masked writeback toward the vector register file.

## Interface
- LANES, 16, lanes per vector row
- DATA_W, 32, bits per lane
- ADDR_W, 6, row address width (DMEM depth 2^ADDR_W rows)
- BEAT_LANES, 4, lanes per memory beat; LANES % BEAT_LANES must be 0, else elaboration error
- REG_AW, 3, vector register index width
- Derived: NBEATS = LANES/BEAT_LANES; BW = max(1, clog2(NBEATS))

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept
- req_is_store  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  row address
- req_mask  in  LANES  lane enable, bit i = lane i
- req_wdata  in  LANES*DATA_W  store data, lane i at [i*DATA_W +: DATA_W]
- req_dest  in  REG_AW  load destination register
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write strobe qualifier
- mem_row  out  ADDR_W  row
- mem_beat  out  BW  beat index within row
- mem_wdata  out  BEAT_LANES*DATA_W  store beat data
- mem_wstrb  out  BEAT_LANES  per-lane write enable
- mem_rdata  in  BEAT_LANES*DATA_W  read data, valid the cycle after a read issue
- wb_valid  out  1  one-cycle load writeback pulse
- wb_dest  out  REG_AW  writeback register
- wb_data  out  LANES*DATA_W  loaded row; unmasked lanes are 0
- wb_mask  out  LANES  lanes to write
- done  out  1  one-cycle completion pulse (load and store)
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - req_ready = 1.
  - On req_valid, latch is_store, addr, mask, wdata, dest; clear wb_data.
  - Compute beat_act[b] = |mask[b*BEAT_LANES +: BEAT_LANES].
  - If beat_act == 0, go to DONE. Otherwise go to ISSUE with ptr = lowest active beat.
- **ISSUE**
  - Drive mem_en = 1, mem_we = is_store, mem_row = addr, mem_beat = ptr.
  - Drive mem_wstrb = mask slice of ptr (loads also drive the slice; memory ignores it when mem_we = 0).
  - Drive mem_wdata = wdata slice of ptr.
  - Next cycle, ptr = next higher active beat.
  - On the last active beat: store goes to DONE; load goes to DRAIN.
- **Load capture**
  - Register the issued beat index for one cycle as cap_beat, with cap_valid.
  - On cap_valid, write mem_rdata lane j into wb_data lane cap_beat*BEAT_LANES + j only where that mask bit is 1. Other lanes stay 0.
  - Capture overlaps ISSUE of the following beat.
- **DRAIN**: captures the final load beat, then goes to DONE.
- **DONE**
  - done = 1.
  - If load: wb_valid = 1, wb_dest = dest, wb_mask = mask, wb_data = assembled row.
  - Always return to IDLE; req_ready = 0 in this state.
- Zero-mask load: no memory access; wb_valid pulses with wb_mask = 0 and wb_data = 0.
- wb_dest, wb_data and wb_mask hold their values after DONE until the next acceptance.

## Timing
- Cycle 0 is the accepting edge. N = number of active beats.
- ISSUE occupies cycles 1..N.
- Store: done in cycle N+1.
- Load: DRAIN in cycle N+1; done and wb_valid in cycle N+2.
- Zero mask: done in cycle 1.
- Throughput: the next request is accepted the cycle after DONE; there is no back-to-back overlap.
- req_ready = (state == IDLE), purely combinational from state. Requests while busy are not accepted; req_valid may be held.
- Reset values: state IDLE, so req_ready = 1 and busy = 0. mem_en, mem_we, mem_wstrb, wb_valid and done are 0. mem_row, mem_beat, mem_wdata, wb_dest, wb_data and wb_mask are 0.
- Reset mid-operation: all outputs take reset values immediately (asynchronous). No done or wb_valid is produced for the aborted request. Partially written store beats remain in memory.
- NBEATS = 1: single beat; mem_beat is constant 0.

## Test plan
1. Defaults, store, mask FFFF, addr 5, lane i data = 101+2i:
   - Beats 0..3 issued in cycles 1..4 with mem_we = 1 and wstrb = F.
   - done in cycle 5.
   - Memory model row 5 holds 101..131.
2. Load, mask FFFF, addr 5, dest 4, after test 1:
   - Reads in cycles 1..4.
   - wb_valid in cycle 6 with wb_dest = 4, wb_mask = FFFF, wb_data = 101..131.
3. Load, mask 16'h0F01, addr 5:
   - Only beats 0 and 2 issued (cycles 1, 2).
   - wb_valid in cycle 4.
   - wb_data: lane 0 = 101, lanes 8..11 = 117..123, all other lanes = 0.
4. Store, mask 0000:
   - mem_en never asserted.
   - done in cycle 1; wb_valid stays 0.
   - Repeat as a load: wb_valid in cycle 1 with wb_mask = 0.
5. Second request with req_valid held during a busy store:
   - req_ready stays 0.
   - Second request accepted on the first cycle state is back in IDLE (the cycle after done).
6. rst_n low during ISSUE of a full-mask store, after beat 1:
   - mem_en drops immediately; no done.
   - After release, req_ready = 1 and test 2 completes correctly.
